nios2_mul_pipe: RTL and testbench

NIOS2_MUL_PIPE -- requirements
Module: nios2_mul_pipe

---
 rtl/nios2_mul_pkg.sv | 27 ++
 rtl/nios2_mul_pp.sv | 25 ++
 rtl/nios2_mul_pipe.sv | 128 ++++++++++++
 tb/tb_nios2_mul_pipe.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_mul_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nios2_mul_pkg : op encoding and parameter limits for the multiply pipe
// Rev 1.0
// ---------------------------------------------------------------------------
package nios2_mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } mul_op_t;

  localparam int WIDTH_MIN = 16;
  localparam int WIDTH_MAX = 64;

  function automatic logic op_a_signed(mul_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  function automatic logic op_b_signed(mul_op_t op);
    return (op == OP_MULH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nios2_mul_pp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nios2_mul_pp : registered unsigned W x W multiplier with load enable
// Rev 1.0
// ---------------------------------------------------------------------------
module nios2_mul_pp #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           i_en,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_p
);

  logic [2*W-1:0] r_p;

  always_ff @(posedge clk) begin
    if (i_en) r_p <= {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
  end

  assign o_p = r_p;

endmodule
`default_nettype wire

// File: rtl/nios2_mul_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nios2_mul_pipe : two-stage MUL/MULH/MULHSU/MULHU pipe with valid/ready.
// NIOS2_MUL_PIPE_MULH_EN enables the high-half ops; otherwise every op is MUL.
// Rev 1.0
// ---------------------------------------------------------------------------
module nios2_mul_pipe
  import nios2_mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int c_HALF = WIDTH / 2;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || (WIDTH % 2) != 0) begin : g_bad_width
    $error("nios2_mul_pipe: WIDTH out of range or odd");
  end

  logic             w_advance;
  logic             r_s1_valid;
  logic             r_s2_valid;
  logic [TAG_W-1:0] r_s1_tag;
  logic [WIDTH-1:0] r_out_result;
  logic [TAG_W-1:0] r_out_tag;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_pp_ll;
  logic [WIDTH-1:0] w_pp_lh;
  logic [WIDTH-1:0] w_pp_hl;

  assign w_advance = !r_s2_valid || out_ready;
  assign in_ready  = w_advance;

  nios2_mul_pp #(.W(c_HALF)) u_pp_ll (
    .clk(clk), .i_en(w_advance),
    .i_a(in_src1[c_HALF-1:0]), .i_b(in_src2[c_HALF-1:0]), .o_p(w_pp_ll)
  );
  nios2_mul_pp #(.W(c_HALF)) u_pp_lh (
    .clk(clk), .i_en(w_advance),
    .i_a(in_src1[c_HALF-1:0]), .i_b(in_src2[WIDTH-1:c_HALF]), .o_p(w_pp_lh)
  );
  nios2_mul_pp #(.W(c_HALF)) u_pp_hl (
    .clk(clk), .i_en(w_advance),
    .i_a(in_src1[WIDTH-1:c_HALF]), .i_b(in_src2[c_HALF-1:0]), .o_p(w_pp_hl)
  );

`ifdef NIOS2_MUL_PIPE_MULH_EN
  logic [WIDTH-1:0]   w_pp_hh;
  mul_op_t            r_s1_op;
  logic               r_s1_a_sgn;
  logic               r_s1_b_sgn;
  logic [WIDTH-1:0]   r_s1_a;
  logic [WIDTH-1:0]   r_s1_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_corr;
  logic [2*WIDTH-1:0] w_prod_s;

  nios2_mul_pp #(.W(c_HALF)) u_pp_hh (
    .clk(clk), .i_en(w_advance),
    .i_a(in_src1[WIDTH-1:c_HALF]), .i_b(in_src2[WIDTH-1:c_HALF]), .o_p(w_pp_hh)
  );

  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_s1_op    <= mul_op_t'(in_op);
      r_s1_a_sgn <= op_a_signed(mul_op_t'(in_op)) & in_src1[WIDTH-1];
      r_s1_b_sgn <= op_b_signed(mul_op_t'(in_op)) & in_src2[WIDTH-1];
      r_s1_a     <= in_src1;
      r_s1_b     <= in_src2;
    end
  end

  // Signed product = unsigned product - (sA ? B : 0)<<W - (sB ? A : 0)<<W, mod 2^(2W).
  assign w_prod = {w_pp_hh, w_pp_ll}
                + {{c_HALF{1'b0}}, w_pp_lh, {c_HALF{1'b0}}}
                + {{c_HALF{1'b0}}, w_pp_hl, {c_HALF{1'b0}}};
  assign w_corr   = (r_s1_a_sgn ? r_s1_b : '0) + (r_s1_b_sgn ? r_s1_a : '0);
  assign w_prod_s = w_prod - {w_corr, {WIDTH{1'b0}}};
  assign w_result = (r_s1_op == OP_MUL) ? w_prod_s[WIDTH-1:0] : w_prod_s[2*WIDTH-1:WIDTH];
`else
  logic w_unused_bits;

  // Only the low product half exists here, so cross terms contribute their low halves only.
  assign w_result = w_pp_ll
                  + {w_pp_lh[c_HALF-1:0], {c_HALF{1'b0}}}
                  + {w_pp_hl[c_HALF-1:0], {c_HALF{1'b0}}};
  assign w_unused_bits = ^{in_op, w_pp_lh[WIDTH-1:c_HALF], w_pp_hl[WIDTH-1:c_HALF]};
`endif

  always_ff @(posedge clk) begin
    if (w_advance) r_s1_tag <= in_tag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid   <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_result <= w_result;
        r_out_tag    <= r_s1_tag;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;

endmodule
`default_nettype wire

// File: tb/tb_nios2_mul_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_nios2_mul_pipe : table vectors plus scoreboard sequences for nios2_mul_pipe
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_nios2_mul_pipe;

  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [W-1:0]  in_src1;
  logic [W-1:0]  in_src2;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;

  nios2_mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    int            step;
    bit            chk_lat;
  } sb_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  sb_t  sb_q[$];
  vec_t tbl[10];
  int   total = 0;
  int   bad   = 0;
  int   stepn = 0;
  int   n_out = 0;
  bit   lat_mode = 1'b0;
  bit   rst_drv  = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
`ifdef NIOS2_MUL_PIPE_MULH_EN
    ea = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == 2'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == 2'd0) ? p[31:0] : p[63:32];
`else
    ea = {32'b0, a};
    eb = {32'b0, b};
    p  = ea * eb;
    return p[31:0];
`endif
  endfunction

  // One cycle: drive at negedge, settle, score the output handshake, record acceptance.
  task automatic step(input bit v, input logic [1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [TW-1:0] tag,
                      input logic [W-1:0] exp, input bit ordy, output bit acc);
    sb_t e;
    @(negedge clk);
    reset = rst_drv; in_valid = v; in_op = op; in_src1 = a; in_src2 = b;
    in_tag = tag; out_ready = ordy;
    #1;
    acc = 1'b0;
    if (!reset) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sb_q.size() == 0) chk("spurious_out_valid", {63'b0, out_valid}, 64'd0);
        else begin
          e = sb_q.pop_front();
          chk("result", {32'b0, out_result}, {32'b0, e.res});
          chk("tag", {59'b0, out_tag}, {59'b0, e.tag});
          if (e.chk_lat) chk("latency", 64'(stepn - e.step), 64'd2);
        end
      end
      if (v && in_ready) begin
        sb_q.push_back('{exp, tag, stepn, lat_mode});
        acc = 1'b1;
      end
    end
    stepn++;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, '0, '0, '0, 1'b1, acc);
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag, input logic [W-1:0] exp);
    bit acc;
    int n;
    n = 0;
    do begin
      step(1'b1, op, a, b, tag, exp, 1'b1, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("accept_timeout", {63'b0, in_ready}, 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 20) begin
      idle(1);
      n++;
    end
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit          acc;
    int          first, last, cnt, k, pend, nout0;
    logic [W-1:0]  hold_res;
    logic [TW-1:0] hold_tag;
    logic [1:0]  rop;
    logic [W-1:0] ra, rb;

`ifdef NIOS2_MUL_PIPE_MULH_EN
    tbl[0] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    tbl[1] = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    tbl[2] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    tbl[3] = '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[4] = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    tbl[5] = '{2'd2, 32'h80000000, 32'h00000002, 32'hFFFFFFFF};
    tbl[6] = '{2'd3, 32'h00010000, 32'h00010000, 32'h00000001};
    tbl[7] = '{2'd0, 32'h00000003, 32'h00000005, 32'h0000000F};
    tbl[8] = '{2'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
    tbl[9] = '{2'd2, 32'h00000002, 32'hFFFFFFFF, 32'h00000001};
`else
    tbl[0] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    tbl[1] = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    tbl[2] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    tbl[3] = '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    tbl[4] = '{2'd1, 32'h80000000, 32'h80000000, 32'h00000000};
    tbl[5] = '{2'd2, 32'h80000000, 32'h00000002, 32'h00000000};
    tbl[6] = '{2'd3, 32'h00010000, 32'h00010000, 32'h00000000};
    tbl[7] = '{2'd0, 32'h00000003, 32'h00000005, 32'h0000000F};
    tbl[8] = '{2'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE};
    tbl[9] = '{2'd2, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
`endif

    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_src1 = '0; in_src2 = '0;
    in_tag = '0; out_ready = 1'b1;

    // reset with in_valid asserted: nothing may be accepted
    rst_drv = 1'b1;
    step(1'b1, 2'd0, 32'd7, 32'd9, 5'd3, '0, 1'b1, acc);
    step(1'b1, 2'd0, 32'd7, 32'd9, 5'd3, '0, 1'b1, acc);
    rst_drv = 1'b0;
    idle(1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_result", {32'b0, out_result}, 64'd0);
    chk("rst_out_tag", {59'b0, out_tag}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    idle(2);
    chk("rst_no_stale", {63'b0, out_valid}, 64'd0);

    // table vectors, each isolated so latency is exactly two edges
    lat_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, TW'(i + 1), tbl[i].exp);
      idle(3);
    end
    drain();

    // eight back-to-back ops, tags 0..7
    first = -1; last = -1; cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) begin
        step(1'b1, 2'd0, 32'(i + 2), 32'(i + 10), TW'(i), model(2'd0, 32'(i + 2), 32'(i + 10)),
             1'b1, acc);
        chk("b2b_accept", {63'b0, acc}, 64'd1);
      end else idle(1);
      if (out_valid) begin
        if (first < 0) first = i;
        last = i;
        cnt++;
      end
    end
    chk("b2b_count", 64'(cnt), 64'd8);
    chk("b2b_span", 64'(last - first + 1), 64'd8);
    chk("b2b_first", 64'(first), 64'd2);

    // three-cycle stall while issuing continuously
    lat_mode = 1'b0;
    nout0 = n_out; pend = 0; k = 0;
    while (pend < 6 && k < 30) begin
      ra = 32'h1000 + 32'(pend * 77);
      rb = 32'hFFFF0000 - 32'(pend);
      step(1'b1, 2'(pend), ra, rb, TW'(pend + 16), model(2'(pend), ra, rb),
           !(k >= 2 && k <= 4), acc);
      if (k == 2) begin hold_res = out_result; hold_tag = out_tag; end
      if (k >= 2 && k <= 4) begin
        chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
        chk("stall_out_valid", {63'b0, out_valid}, 64'd1);
        chk("stall_result_hold", {32'b0, out_result}, {32'b0, hold_res});
        chk("stall_tag_hold", {59'b0, out_tag}, {59'b0, hold_tag});
      end
      if (acc) pend++;
      k++;
    end
    drain();
    chk("stall_out_count", 64'(n_out - nout0), 64'd6);

    // random traffic with random back-pressure
    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom; rb = $urandom;
      step($urandom_range(0, 3) != 0, rop, ra, rb, TW'(i), model(rop, ra, rb),
           $urandom_range(0, 3) != 0, acc);
    end
    drain();

    // reset with two ops in flight
    step(1'b1, 2'd0, 32'd3, 32'd5, 5'd9, 32'd15, 1'b1, acc);
    step(1'b1, 2'd0, 32'd6, 32'd7, 5'd10, 32'd42, 1'b1, acc);
    rst_drv = 1'b1;
    step(1'b1, 2'd0, 32'd11, 32'd13, 5'd11, '0, 1'b1, acc);
    rst_drv = 1'b0;
    sb_q.delete();
    idle(1);
    chk("flight_rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("flight_rst_out_result", {32'b0, out_result}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("flight_rst_no_stale", {63'b0, out_valid}, 64'd0);
    end
    lat_mode = 1'b1;
    issue(2'd0, 32'd9, 32'd9, 5'd21, 32'd81);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
